// File: rtl/modulo_es.sv
// Memory-mapped I/O responder: four output ports, four synchronized input ports.
// Optional prescaled down-counting timer with flag and irq, built when ES_TIMER_EN is defined.
module modulo_es #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        activar,
    input  logic        escribir,
    input  logic [6:0]  dir,
    input  logic [7:0]  dato_in,
    output logic [7:0]  dato_out,
    input  logic [31:0] entradas,
    output logic [31:0] salidas,
    output logic        irq
);

    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("modulo_es: PRESCALE must be in 1..255");
    end

    logic        we;
    logic        sel_out;
    logic        sel_in;
    logic [4:0]  lane;
    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] outs;
    logic [7:0]  rdata;

    assign we      = activar & escribir;
    assign sel_out = (dir[6:2] == 5'd0);
    assign sel_in  = (dir[6:2] == 5'd1);
    assign lane    = {dir[1:0], 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            outs  <= '0;
        end else begin
            sync1 <= entradas;
            sync2 <= sync1;
            if (we && sel_out)
                outs[lane +: 8] <= dato_in;
        end
    end

    assign salidas = outs;

`ifdef ES_TIMER_EN
    localparam logic [7:0] PMAX = 8'(PRESCALE - 1);

    logic [7:0] reload;
    logic [7:0] count;
    logic [7:0] presc;
    logic       en;
    logic       ar;
    logic       ie;
    logic       flag;
    logic       irq_q;
    logic       wr_reload;
    logic       wr_ctrl;
    logic       wr_stat;
    logic       tick;
    logic       expire;

    assign wr_reload = we && (dir == 7'h08);
    assign wr_ctrl   = we && (dir == 7'h09);
    assign wr_stat   = we && (dir == 7'h0A);
    assign tick      = en && (presc == PMAX);
    assign expire    = tick && (count == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
            count  <= '0;
            presc  <= '0;
            en     <= 1'b0;
            ar     <= 1'b0;
            ie     <= 1'b0;
            flag   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            // Enabling from idle restarts the prescale phase
            if (wr_ctrl && dato_in[0] && !en)
                presc <= '0;
            else if (en)
                presc <= tick ? 8'd0 : presc + 8'd1;

            if (wr_reload)
                reload <= dato_in;

            if (wr_reload)
                count <= dato_in;
            else if (tick) begin
                if (count != 8'd0)
                    count <= count - 8'd1;
                else if (ar)
                    count <= reload;
            end

            if (wr_ctrl) begin
                en <= dato_in[0];
                ar <= dato_in[1];
                ie <= dato_in[2];
            end else if (expire && !ar) begin
                en <= 1'b0;
            end

            // Expiry beats a simultaneous W1C
            if (expire)
                flag <= 1'b1;
            else if (wr_stat && dato_in[0])
                flag <= 1'b0;

            irq_q <= flag & ie;
        end
    end

    assign irq = irq_q;

    always_comb begin
        rdata = 8'h00;
        unique case (1'b1)
            sel_out:           rdata = outs[lane +: 8];
            sel_in:            rdata = sync2[lane +: 8];
            (dir == 7'h08):    rdata = reload;
            (dir == 7'h09):    rdata = {5'b0, ie, ar, en};
            (dir == 7'h0A):    rdata = {7'b0, flag};
            (dir == 7'h0B):    rdata = count;
            default:           rdata = 8'h00;
        endcase
    end
`else
    assign irq = 1'b0;

    always_comb begin
        rdata = 8'h00;
        unique case (1'b1)
            sel_out: rdata = outs[lane +: 8];
            sel_in:  rdata = sync2[lane +: 8];
            default: rdata = 8'h00;
        endcase
    end
`endif

    assign dato_out = activar ? rdata : 8'h00;

endmodule

// File: tb/tb_modulo_es.sv
// Scoreboard bench for modulo_es: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_modulo_es;

    logic        clk = 1'b0;
    logic        reset;
    logic        activar;
    logic        escribir;
    logic [6:0]  dir;
    logic [7:0]  dato_in;
    logic [7:0]  dato_out;
    logic [31:0] entradas;
    logic [31:0] salidas;
    logic        irq;

    always #5 clk = ~clk;

    modulo_es #(.PRESCALE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .activar  (activar),
        .escribir (escribir),
        .dir      (dir),
        .dato_in  (dato_in),
        .dato_out (dato_out),
        .entradas (entradas),
        .salidas  (salidas),
        .irq      (irq)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    // sel: 0 = dato_out, 1 = salidas, 2 = irq
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t       it;
            logic [31:0] act;
            it = sb.pop_front();
            case (it.sel)
                0:       act = {24'b0, dato_out};
                1:       act = salidas;
                default: act = {31'b0, irq};
            endcase
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int s, input logic [31:0] e);
        item_t it;
        it.name = n;
        it.sel  = s;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string n, input int s, input logic [31:0] e);
        expect_v(n, s, e);
        idle(1);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        activar  = 1'b1;
        escribir = 1'b1;
        dir      = a;
        dato_in  = d;
        idle(1);
        activar  = 1'b0;
        escribir = 1'b0;
    endtask

    task automatic rdx(input logic act, input logic wen, input logic [6:0] a,
                       input logic [7:0] e, input string n);
        activar  = act;
        escribir = wen;
        dir      = a;
        dato_in  = 8'hFF;
        expect_v(n, 0, {24'b0, e});
        idle(1);
        activar  = 1'b0;
        escribir = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] e, input string n);
        rdx(1'b1, 1'b0, a, e, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        activar  = 1'b0;
        escribir = 1'b0;
        dir      = '0;
        dato_in  = '0;
        entradas = 32'hA5A5A5A5;
        idle(2);
        reset = 1'b0;

        expect_v("rst_salidas", 1, 32'h0);
        chk("rst_irq", 2, 32'h0);
        idle(1);
        rd(7'h05, 8'hA5, "in1_after_sync");
        rdx(1'b0, 1'b0, 7'h05, 8'h00, "rd_inactive");

        wr(7'h02, 8'h3C);
        chk("out2_only", 1, 32'h003C0000);
        rd(7'h02, 8'h3C, "rd_out2");
        wr(7'h00, 8'h11);
        wr(7'h03, 8'hC3);
        wr(7'h06, 8'hFF);
        wr(7'h40, 8'hFF);
        chk("ro_unmapped_wr", 1, 32'hC33C0011);
        rd(7'h06, 8'hA5, "in2_unchanged");
        rdx(1'b1, 1'b1, 7'h07, 8'hA5, "rd_with_wen");
        wr(7'h7F, 8'hFF);
        rd(7'h0C, 8'h00, "unmapped_0c");
        rd(7'h7F, 8'h00, "unmapped_7f");

        entradas = 32'h12345678;
        idle(2);
        rd(7'h04, 8'h78, "in0");
        rd(7'h05, 8'h56, "in1");
        rd(7'h06, 8'h34, "in2");
        rd(7'h07, 8'h12, "in3");
        entradas = 32'h1234569A;
        rd(7'h04, 8'h78, "lat_0");
        rd(7'h04, 8'h78, "lat_1");
        rd(7'h04, 8'h9A, "lat_2");

`ifndef ES_TIMER_EN
        wr(7'h09, 8'hFF);
        wr(7'h08, 8'hFF);
        rd(7'h08, 8'h00, "nt_reload");
        rd(7'h09, 8'h00, "nt_ctrl");
        rd(7'h0A, 8'h00, "nt_status");
        rd(7'h0B, 8'h00, "nt_count");
        idle(20);
        chk("nt_irq", 2, 32'h0);
`else
        // Auto-reload: expiry 16 clocks after the CTRL write edge
        do_reset();
        wr(7'h08, 8'd3);
        wr(7'h09, 8'h07);
        for (int i = 0; i < 16; i++)
            rd(7'h0A, 8'h00, "flag_early");
        expect_v("irq_not_yet", 2, 32'h0);
        rd(7'h0A, 8'h01, "flag_set");
        expect_v("irq_follows", 2, 32'h1);
        rd(7'h0B, 8'd3, "count_reload");
        wr(7'h0A, 8'h01);
        rd(7'h0A, 8'h00, "flag_clr");
        chk("irq_fall", 2, 32'h0);

        // One-shot mode
        do_reset();
        wr(7'h08, 8'd3);
        wr(7'h09, 8'h05);
        idle(20);
        rd(7'h09, 8'h04, "oneshot_ctrl");
        rd(7'h0B, 8'h00, "oneshot_count");
        rd(7'h0A, 8'h01, "oneshot_flag");
        chk("oneshot_irq", 2, 32'h1);
        idle(10);
        rd(7'h0B, 8'h00, "oneshot_hold");

        // Simultaneous events
        do_reset();
        wr(7'h08, 8'd3);
        wr(7'h09, 8'h07);
        idle(15);
        wr(7'h0A, 8'h01);
        rd(7'h0A, 8'h01, "w1c_vs_set");
        idle(2);
        wr(7'h08, 8'd9);
        rd(7'h0B, 8'd9, "reload_on_tick");
        idle(2);
        rd(7'h0B, 8'd9, "pre_next_tick");
        rd(7'h0B, 8'd8, "next_tick_dec");

        // Reset mid-count
        do_reset();
        wr(7'h00, 8'h5A);
        wr(7'h08, 8'd2);
        wr(7'h09, 8'h03);
        idle(1);
        reset = 1'b1;
        #1;
        expect_v("mid_rst_salidas", 1, 32'h0);
        expect_v("mid_rst_irq", 2, 32'h0);
        rd(7'h0B, 8'h00, "mid_rst_count");
        rd(7'h08, 8'h00, "mid_rst_reload");
        rd(7'h09, 8'h00, "mid_rst_ctrl");
        reset = 1'b0;
        idle(10);
        rd(7'h0B, 8'h00, "no_resume_count");
        rd(7'h0A, 8'h00, "no_resume_flag");
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
